// File: rtl/proc_trace_pkg.sv
// Shared definitions for the commit trace unit.
//   - Record kind encodings (BARE..HALT) and trace FSM state encodings.
//   - trace_rec_t: packed 134-bit trace record as stored in the FIFO.
//   - classify(): priority classification of a retiring instruction.
package proc_trace_pkg;

    localparam logic [2:0] KIND_BARE  = 3'd0;
    localparam logic [2:0] KIND_REG   = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_STORE = 3'd3;
    localparam logic [2:0] KIND_STU   = 3'd4;
    localparam logic [2:0] KIND_HALT  = 3'd5;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [31:0] cycle;
        logic [15:0] pc;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [2:0]  wreg;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    // Register-writing kinds take precedence over halt, halt over a plain store.
    function automatic logic [2:0] classify(input logic reg_write,
                                            input logic mem_read,
                                            input logic mem_write,
                                            input logic halt);
        if (reg_write && mem_write)     return KIND_STU;
        else if (reg_write && mem_read) return KIND_LOAD;
        else if (reg_write)             return KIND_REG;
        else if (halt)                  return KIND_HALT;
        else if (mem_write)             return KIND_STORE;
        else                            return KIND_BARE;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the commit trace unit.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : record to store
//   pop        : remove head record (ignored when empty)
//   pop_data   : head record, all zeros when empty
//   full/empty : occupancy flags
//   count      : number of stored records
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 134
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == '0);
    assign count   = count_r;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks fullness.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/commit_trace_unit.sv
// Commit trace unit: turns retiring instructions into a stream of trace records.
//   clk, rst          : clock, synchronous active-high reset
//   commit_valid      : an instruction retires this cycle
//   pc, write_data, mem_addr, mem_data, reg_write, mem_read, mem_write, halt,
//   write_reg         : retiring-instruction attributes
//   commit_stall      : FIFO full or unit not in RUN; processor must hold retirement
//   rec_valid/ready   : record stream handshake
//   rec_*             : head record fields, zero when no record is queued
//   overflow          : sticky flag, a commit was dropped while stalled in RUN
//   halted            : halt record consumed and unit idle
module commit_trace_unit
    import proc_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [15:0] pc,
    input  logic [15:0] write_data,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        halt,
    input  logic [2:0]  write_reg,
    output logic        commit_stall,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [2:0]  rec_kind,
    output logic [31:0] rec_inum,
    output logic [31:0] rec_cycle,
    output logic [15:0] rec_pc,
    output logic [15:0] rec_wdata,
    output logic [15:0] rec_addr,
    output logic [15:0] rec_mdata,
    output logic [2:0]  rec_reg,
    output logic        overflow,
    output logic        halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [1:0]       state;
    logic [31:0]      cyc;
    logic [31:0]      inum;
    logic [2:0]       kind;
    logic             accept;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [REC_W-1:0] head_bits;
    trace_rec_t       new_rec;
    trace_rec_t       head;

    assign commit_stall = full || (state != ST_RUN);
    assign accept       = commit_valid && !commit_stall;
    assign pop          = rec_valid && rec_ready;
    assign halted       = (state == ST_DONE);

    always_comb begin
        kind          = classify(reg_write, mem_read, mem_write, halt);
        new_rec       = '0;
        new_rec.kind  = kind;
        new_rec.inum  = inum;
        new_rec.cycle = cyc;
        case (kind)
            KIND_REG: begin
                new_rec.wreg  = write_reg;
                new_rec.wdata = write_data;
            end
            KIND_LOAD: begin
                new_rec.wreg  = write_reg;
                new_rec.wdata = write_data;
                new_rec.addr  = mem_addr;
            end
            KIND_STORE: begin
                new_rec.addr  = mem_addr;
                new_rec.mdata = mem_data;
            end
            KIND_STU: begin
                new_rec.pc    = pc;
                new_rec.wreg  = write_reg;
                new_rec.wdata = write_data;
                new_rec.addr  = mem_addr;
                new_rec.mdata = mem_data;
            end
            default: new_rec.pc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            cyc      <= '0;
            inum     <= '0;
            overflow <= 1'b0;
        end else begin
            cyc <= cyc + 1'b1;
            if (accept) inum <= inum + 1'b1;
            // Only a full FIFO in RUN drops commits; DRAIN/DONE ignore them silently.
            if (commit_valid && (state == ST_RUN) && full) overflow <= 1'b1;
            case (state)
                ST_RUN:   if (accept && (kind == KIND_HALT)) state <= ST_DRAIN;
                // No pushes happen in DRAIN, so a pop at count 1 empties the FIFO.
                ST_DRAIN: if (pop && (count == CW'(1))) state <= ST_DONE;
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_RUN;
            endcase
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (new_rec),
        .pop       (pop),
        .pop_data  (head_bits),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head      = trace_rec_t'(head_bits);
    assign rec_valid = !empty;
    assign rec_kind  = head.kind;
    assign rec_inum  = head.inum;
    assign rec_cycle = head.cycle;
    assign rec_pc    = head.pc;
    assign rec_wdata = head.wdata;
    assign rec_addr  = head.addr;
    assign rec_mdata = head.mdata;
    assign rec_reg   = head.wreg;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Self-checking bench for commit_trace_unit (DEPTH=4).
`timescale 1ns/1ps
module tb_commit_trace_unit;
    import proc_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [15:0] pc, write_data, mem_addr, mem_data;
    logic        reg_write, mem_read, mem_write, halt;
    logic [2:0]  write_reg;
    logic        commit_stall;
    logic        rec_valid;
    logic        rec_ready;
    logic [2:0]  rec_kind;
    logic [31:0] rec_inum, rec_cycle;
    logic [15:0] rec_pc, rec_wdata, rec_addr, rec_mdata;
    logic [2:0]  rec_reg;
    logic        overflow, halted;

    always #5 clk = ~clk;

    commit_trace_unit #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .pc           (pc),
        .write_data   (write_data),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .halt         (halt),
        .write_reg    (write_reg),
        .commit_stall (commit_stall),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_kind     (rec_kind),
        .rec_inum     (rec_inum),
        .rec_cycle    (rec_cycle),
        .rec_pc       (rec_pc),
        .rec_wdata    (rec_wdata),
        .rec_addr     (rec_addr),
        .rec_mdata    (rec_mdata),
        .rec_reg      (rec_reg),
        .overflow     (overflow),
        .halted       (halted)
    );

    trace_rec_t  sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] m_cyc  = '0;
    logic [31:0] m_inum = '0;

    // Cycle number the DUT should stamp on a commit accepted at the next edge.
    always @(posedge clk) begin
        if (rst) m_cyc <= '0;
        else     m_cyc <= m_cyc + 1;
    end

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic trace_rec_t mk(input logic [2:0] k, input logic [31:0] n,
                                      input logic [31:0] c, input logic [15:0] p,
                                      input logic [15:0] wd, input logic [15:0] a,
                                      input logic [15:0] md, input logic [2:0] r);
        trace_rec_t t;
        t       = '0;
        t.kind  = k;
        t.inum  = n;
        t.cycle = c;
        if (k == KIND_REG || k == KIND_LOAD || k == KIND_STU) begin
            t.wreg  = r;
            t.wdata = wd;
        end
        if (k == KIND_LOAD || k == KIND_STORE || k == KIND_STU) t.addr = a;
        if (k == KIND_STORE || k == KIND_STU) t.mdata = md;
        if (k == KIND_STU || k == KIND_BARE || k == KIND_HALT) t.pc = p;
        return t;
    endfunction

    // Scoreboard consumer: every handshake must match the oldest expected record.
    trace_rec_t got_rec;
    trace_rec_t exp_rec;
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            got_rec = '{kind: rec_kind, inum: rec_inum, cycle: rec_cycle, pc: rec_pc,
                        wdata: rec_wdata, addr: rec_addr, mdata: rec_mdata, wreg: rec_reg};
            if (sb.size() == 0) begin
                check("unexpected_record", got_rec, '0);
            end else begin
                exp_rec = sb.pop_front();
                check("record", got_rec, exp_rec);
            end
        end
    end

    task automatic do_commit(input logic [15:0] p, input logic [15:0] wd,
                             input logic [15:0] a, input logic [15:0] md,
                             input logic [2:0] wr, input logic rw, input logic mr,
                             input logic mw, input logic h,
                             input logic [2:0] exp_kind, input bit accept);
        pc = p; write_data = wd; mem_addr = a; mem_data = md; write_reg = wr;
        reg_write = rw; mem_read = mr; mem_write = mw; halt = h;
        commit_valid = 1'b1;
        if (accept) begin
            sb.push_back(mk(exp_kind, m_inum, m_cyc, p, wd, a, md, wr));
            m_inum++;
        end
        @(posedge clk); #1;
        commit_valid = 1'b0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_inum = '0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        rec_ready = 1'b1;
        while (sb.size() != 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        check("drain_empty_valid", rec_valid, 0);
        check("drain_empty_data", {rec_kind, rec_inum, rec_cycle, rec_pc, rec_wdata,
                                   rec_addr, rec_mdata, rec_reg}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; commit_valid = 1'b0; rec_ready = 1'b0;
        pc = '0; write_data = '0; mem_addr = '0; mem_data = '0; write_reg = '0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check("rst_valid", rec_valid, 0);
        check("rst_stall", commit_stall, 0);
        check("rst_overflow", overflow, 0);
        check("rst_halted", halted, 0);
        check("rst_data", {rec_kind, rec_inum, rec_cycle, rec_pc, rec_wdata,
                           rec_addr, rec_mdata, rec_reg}, 0);

        // REG kind, commit at cyc=5, latency 1
        rec_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        do_commit(16'h0002, 16'h1234, 16'h5555, 16'h6666, 3'd3, 1, 0, 0, 0, KIND_REG, 1);
        check("reg_latency_valid", rec_valid, 1);
        check("reg_latency_cycle", rec_cycle, 32'd5);
        @(posedge clk); #1;

        // Classification, including priority corners
        do_commit(16'h0010, 16'hAAAA, 16'h0040, 16'hBEEF, 3'd5, 1, 0, 1, 0, KIND_STU, 1);
        do_commit(16'h0010, 16'hAAAA, 16'h0040, 16'hBEEF, 3'd5, 0, 0, 1, 0, KIND_STORE, 1);
        do_commit(16'h0012, 16'h0BAD, 16'h0080, 16'hCAFE, 3'd2, 1, 1, 0, 0, KIND_LOAD, 1);
        do_commit(16'h0014, 16'h1111, 16'h2222, 16'h3333, 3'd6, 1, 0, 0, 1, KIND_REG, 1);
        do_commit(16'h0016, 16'h4444, 16'h5555, 16'h6666, 3'd1, 0, 1, 0, 0, KIND_BARE, 1);
        drain();

        // Backpressure and overflow
        rec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++)
            do_commit(16'h0100 + 16'(i), 16'h0A00 + 16'(i), 16'h0, 16'h0, 3'(i + 1),
                      1, 0, 0, 0, KIND_REG, 1);
        check("bp_stall_full", commit_stall, 1);
        check("bp_overflow_before", overflow, 0);
        do_commit(16'h0200, 16'h0B00, 16'h0, 16'h0, 3'd7, 1, 0, 0, 0, KIND_REG, 0);
        check("bp_overflow_set", overflow, 1);
        repeat (2) begin
            @(posedge clk); #1;
            check("bp_hold_valid", rec_valid, 1);
            check("bp_hold_inum", rec_inum, 0);
            check("bp_hold_wdata", rec_wdata, 16'h0A00);
        end
        drain();
        check("bp_stall_clear", commit_stall, 0);
        check("bp_overflow_sticky", overflow, 1);

        // Simultaneous push and pop at count 2
        rec_ready = 1'b0;
        do_reset();
        do_commit(16'h0300, 16'h0C00, 16'h0, 16'h0, 3'd1, 1, 0, 0, 0, KIND_REG, 1);
        do_commit(16'h0301, 16'h0C01, 16'h0, 16'h0, 3'd2, 1, 0, 0, 0, KIND_REG, 1);
        rec_ready = 1'b1;
        do_commit(16'h0302, 16'h0C02, 16'h0, 16'h0, 3'd3, 1, 0, 0, 0, KIND_REG, 1);
        rec_ready = 1'b0;
        check("pp_head_inum", rec_inum, 1);
        check("pp_stall", commit_stall, 0);
        do_commit(16'h0303, 16'h0C03, 16'h0, 16'h0, 3'd4, 1, 0, 0, 0, KIND_REG, 1);
        check("pp_count3_stall", commit_stall, 0);
        do_commit(16'h0304, 16'h0C04, 16'h0, 16'h0, 3'd5, 1, 0, 0, 0, KIND_REG, 1);
        check("pp_count4_stall", commit_stall, 1);
        drain();

        // Halt and drain to DONE
        rec_ready = 1'b0;
        do_reset();
        do_commit(16'h0018, 16'h0D00, 16'h0, 16'h0, 3'd1, 1, 0, 0, 0, KIND_REG, 1);
        do_commit(16'h0019, 16'h0D01, 16'h0, 16'h0, 3'd2, 1, 0, 0, 0, KIND_REG, 1);
        do_commit(16'h001A, 16'h7777, 16'h8888, 16'h9999, 3'd7, 0, 0, 0, 1, KIND_HALT, 1);
        check("halt_stall_drain", commit_stall, 1);
        check("halt_not_yet", halted, 0);
        do_commit(16'h001B, 16'h0, 16'h00F0, 16'h00F1, 3'd0, 0, 0, 1, 0, KIND_STORE, 0);
        check("halt_ignore_no_overflow", overflow, 0);
        rec_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("halt_before_last_pop", halted, 0);
        @(posedge clk); #1;
        check("halt_done", halted, 1);
        check("halt_empty_valid", rec_valid, 0);
        check("halt_sb_empty", sb.size(), 0);
        do_commit(16'h001C, 16'h1, 16'h2, 16'h3, 3'd1, 1, 0, 0, 0, KIND_REG, 0);
        check("done_ignore_valid", rec_valid, 0);
        check("done_ignore_overflow", overflow, 0);
        check("done_stays", halted, 1);

        // Mid-operation reset with a simultaneous commit and pop
        rec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++)
            do_commit(16'h0400 + 16'(i), 16'h0E00 + 16'(i), 16'h0, 16'h0, 3'(i),
                      1, 0, 0, 0, KIND_REG, 1);
        do_commit(16'h0500, 16'h0F00, 16'h0, 16'h0, 3'd1, 1, 0, 0, 0, KIND_REG, 0);
        check("mr_overflow_pre", overflow, 1);
        rst = 1'b1;
        commit_valid = 1'b1; reg_write = 1'b1; pc = 16'h0600; write_data = 16'h0F0F;
        rec_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; commit_valid = 1'b0; reg_write = 1'b0; rec_ready = 1'b0;
        sb.delete();
        m_inum = '0;
        check("mr_valid", rec_valid, 0);
        check("mr_overflow", overflow, 0);
        check("mr_stall", commit_stall, 0);
        check("mr_halted", halted, 0);
        do_commit(16'h0700, 16'h0123, 16'h0, 16'h0, 3'd4, 1, 0, 0, 0, KIND_REG, 1);
        check("mr_first_cycle", rec_cycle, 0);
        check("mr_first_inum", rec_inum, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
